// File: rtl/fpnew_divsqrt_iter_core_if.sv
// Start/ready/done/kill handshake plus operand and result bus between the
// multi-cycle divsqrt wrapper (master) and the iterative mantissa core (slave).
interface fpnew_divsqrt_iter_core_if #(
    parameter int unsigned WIDTH = 24
);
    logic               div_start_i;
    logic               sqrt_start_i;
    logic [WIDTH-1:0]   op_a_i;
    logic [WIDTH-1:0]   op_b_i;
    logic               kill_i;
    logic               ready_o;
    logic               done_o;
    logic [WIDTH+1:0]   result_o;
    logic               sticky_o;
    logic               div_zero_o;

    modport master (
        output div_start_i, sqrt_start_i, op_a_i, op_b_i, kill_i,
        input  ready_o, done_o, result_o, sticky_o, div_zero_o
    );

    modport slave (
        input  div_start_i, sqrt_start_i, op_a_i, op_b_i, kill_i,
        output ready_o, done_o, result_o, sticky_o, div_zero_o
    );
endinterface

// File: rtl/fpnew_divsqrt_iter_core.sv
// Iterative radix-2 restoring mantissa divider / square-root engine.
// One result bit per cycle over WIDTH+2 cycles; returns a truncated
// quotient/root and a sticky bit. Sign, exponent, rounding and special
// cases are handled by the surrounding wrapper.
module fpnew_divsqrt_iter_core #(
    parameter int unsigned WIDTH = 24
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    fpnew_divsqrt_iter_core_if.slave      io
);

    localparam int unsigned N     = WIDTH + 2;          // iterations / result bits
    localparam int unsigned QW    = WIDTH + 2;          // quotient / root width
    localparam int unsigned REM_W = 2 * WIDTH + 4;      // shared remainder width
    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic               done_q;
    logic [QW-1:0]      result_q;
    logic               sticky_q;
    logic               div_zero_q;

    // iteration state
    logic               is_sqrt_q;
    logic               dz_pend_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [REM_W-1:0]   rem_q;
    logic [REM_W-1:0]   rad_q;
    logic [QW-1:0]      quo_q;

    // next iteration values
    logic [REM_W-1:0]   rem_d;
    logic [REM_W-1:0]   rad_d;
    logic [QW-1:0]      quo_d;

    logic               start_s;
    logic               start_sqrt_s;
    logic               ld_dz_s;
    logic [REM_W-1:0]   ld_rem_s;
    logic [REM_W-1:0]   ld_rad_s;

    logic [QW:0]        div_diff_s;
    logic [REM_W-1:0]   sqrt_acc_s;
    logic [REM_W-1:0]   sqrt_trial_s;
    logic [REM_W:0]     sqrt_diff_s;

    // Start acceptance and the initial iteration state for the selected operation
    always_comb begin
        start_s      = (io.div_start_i | io.sqrt_start_i) & ready_q & ~io.kill_i;
        start_sqrt_s = ~io.div_start_i;
        ld_dz_s      = 1'b0;
        ld_rem_s     = '0;
        ld_rad_s     = '0;
        if (start_sqrt_s) begin
            // radicand A * 2^(WIDTH+4), consumed two bits per iteration from the top
            ld_rad_s = {io.op_a_i, {(WIDTH + 4){1'b0}}};
        end else begin
            ld_rem_s = {{(REM_W - WIDTH){1'b0}}, io.op_a_i};
            ld_dz_s  = (io.op_b_i == {WIDTH{1'b0}});
        end
    end

    // One restoring iteration: divide (R-B test) or sqrt (trial root 4q+1 test)
    always_comb begin
        rem_d        = rem_q;
        rad_d        = rad_q;
        quo_d        = quo_q;
        div_diff_s   = '0;
        sqrt_acc_s   = '0;
        sqrt_trial_s = '0;
        sqrt_diff_s  = '0;
        if (is_sqrt_q) begin
            sqrt_acc_s   = {rem_q[REM_W-3:0], rad_q[REM_W-1 -: 2]};
            sqrt_trial_s = {{(REM_W - QW - 2){1'b0}}, quo_q, 2'b01};
            sqrt_diff_s  = {1'b0, sqrt_acc_s} - {1'b0, sqrt_trial_s};
            rad_d        = {rad_q[REM_W-3:0], 2'b00};
            if (!sqrt_diff_s[REM_W]) begin
                rem_d = sqrt_diff_s[REM_W-1:0];
                quo_d = {quo_q[QW-2:0], 1'b1};
            end else begin
                rem_d = sqrt_acc_s;
                quo_d = {quo_q[QW-2:0], 1'b0};
            end
        end else begin
            // partial remainder stays below 2*B, so QW bits are enough
            div_diff_s = {1'b0, rem_q[QW-1:0]} - {3'b000, divisor_q};
            if (!div_diff_s[QW]) begin
                rem_d = {{(REM_W - QW){1'b0}}, div_diff_s[QW-2:0], 1'b0};
                quo_d = {quo_q[QW-2:0], 1'b1};
            end else begin
                rem_d = {{(REM_W - QW){1'b0}}, rem_q[QW-2:0], 1'b0};
                quo_d = {quo_q[QW-2:0], 1'b0};
            end
        end
    end

    // Control FSM, iteration registers and committed outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= '0;
            sticky_q   <= 1'b0;
            div_zero_q <= 1'b0;
            is_sqrt_q  <= 1'b0;
            dz_pend_q  <= 1'b0;
            divisor_q  <= '0;
            rem_q      <= '0;
            rad_q      <= '0;
            quo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_s) begin
                        state_q   <= BUSY;
                        cnt_q     <= CNT_W'(N);
                        ready_q   <= 1'b0;
                        is_sqrt_q <= start_sqrt_s;
                        dz_pend_q <= ld_dz_s;
                        divisor_q <= io.op_b_i;
                        rem_q     <= ld_rem_s;
                        rad_q     <= ld_rad_s;
                        quo_q     <= '0;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (io.kill_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        rem_q <= rem_d;
                        rad_q <= rad_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            // last bit: commit directly from the next-iteration values
                            state_q    <= DONE;
                            ready_q    <= 1'b1;
                            done_q     <= 1'b1;
                            result_q   <= dz_pend_q ? {QW{1'b1}} : quo_d;
                            sticky_q   <= dz_pend_q | (rem_d != {REM_W{1'b0}});
                            div_zero_q <= dz_pend_q;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign io.ready_o    = ready_q;
    assign io.done_o     = done_q;
    assign io.result_o   = result_q;
    assign io.sticky_o   = sticky_q;
    assign io.div_zero_o = div_zero_q;

endmodule

// File: tb/tb_fpnew_divsqrt_iter_core.sv
// Self-checking bench for fpnew_divsqrt_iter_core (WIDTH=24): directed cases
// plus randomized divide/sqrt against an arithmetic reference model.
module tb_fpnew_divsqrt_iter_core;

    localparam int W   = 24;
    localparam int LAT = W + 3;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    longint unsigned last_res = 0;

    fpnew_divsqrt_iter_core_if #(.WIDTH(W)) bus ();

    fpnew_divsqrt_iter_core #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the scaled operands
    function automatic void model(input bit sq, input longint unsigned a, input longint unsigned b,
                                  output longint unsigned res, output bit st, output bit dz);
        longint unsigned x, lo, hi, mid;
        if (sq) begin
            x  = a << (W + 4);
            lo = 0;
            hi = 64'd1 << (W + 3);
            while (hi - lo > 1) begin
                mid = (lo + hi) / 2;
                if (mid * mid <= x) lo = mid;
                else hi = mid;
            end
            res = lo;
            st  = (x != lo * lo);
            dz  = 1'b0;
        end else if (b == 0) begin
            res = (64'd1 << (W + 2)) - 1;
            st  = 1'b1;
            dz  = 1'b1;
        end else begin
            x   = a << (W + 1);
            res = x / b;
            st  = (x % b) != 0;
            dz  = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start now (caller ensures ready), then wait for done and check.
    // spur>0 injects an extra start at that BUSY cycle, which must be ignored.
    task automatic go(input bit sq, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int spur, input string tag);
        longint unsigned er;
        bit es, ed;
        int lat;
        bit stable;
        logic [W+1:0] prev;
        model(sq, a, b, er, es, ed);
        prev   = bus.result_o;
        stable = 1'b1;
        bus.div_start_i  = ~sq;
        bus.sqrt_start_i = sq;
        bus.op_a_i = a;
        bus.op_b_i = b;
        tick();
        bus.div_start_i  = 1'b0;
        bus.sqrt_start_i = 1'b0;
        lat = 1;
        while (!bus.done_o && lat < 100) begin
            if (bus.result_o != prev) stable = 1'b0;
            if (lat == spur) begin
                bus.sqrt_start_i = 1'b1;
                bus.op_a_i = 24'hFFFFFF;
            end else begin
                bus.sqrt_start_i = 1'b0;
            end
            tick();
            lat++;
        end
        bus.sqrt_start_i = 1'b0;
        check_val({tag, "_lat"}, lat, LAT);
        check_val({tag, "_res"}, bus.result_o, er);
        check_val({tag, "_sticky"}, bus.sticky_o, es);
        check_val({tag, "_dz"}, bus.div_zero_o, ed);
        check_val({tag, "_stable"}, stable, 1);
        last_res = er;
    endtask

    task automatic run_op(input bit sq, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int g = 0;
        while (!bus.ready_o && g < 100) begin
            tick();
            g++;
        end
        @(negedge clk);
        go(sq, a, b, 0, tag);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.done_o) n++;
        end
    endtask

    initial begin
        int nd;
        logic [W-1:0] ra, rb;

        bus.div_start_i  = 1'b0;
        bus.sqrt_start_i = 1'b0;
        bus.op_a_i = '0;
        bus.op_b_i = '0;
        bus.kill_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_val("rst_ready", bus.ready_o, 1);
        check_val("rst_done", bus.done_o, 0);
        check_val("rst_result", bus.result_o, 0);
        check_val("rst_sticky", bus.sticky_o, 0);
        check_val("rst_dz", bus.div_zero_o, 0);

        // directed cases with literal expectations
        run_op(1'b0, 24'hC00000, 24'h800000, "div_1p5");
        check_val("div_1p5_lit", bus.result_o, 64'h3000000);
        tick();
        check_val("done_pulse_width", bus.done_o, 0);
        check_val("result_hold_idle", bus.result_o, 64'h3000000);
        run_op(1'b0, 24'h800000, 24'hC00000, "div_2_3");
        check_val("div_2_3_lit", bus.result_o, 64'h1555555);
        run_op(1'b1, 24'h800000, 24'h0, "sqrt_2");
        check_val("sqrt_2_lit", bus.result_o, 64'h2D413CC);
        run_op(1'b1, 24'h900000, 24'h0, "sqrt_9");
        check_val("sqrt_9_lit", bus.result_o, 64'h3000000);
        run_op(1'b0, 24'hABCDEF, 24'h0, "div_zero");
        check_val("div_zero_lit", bus.result_o, 64'h3FFFFFF);
        run_op(1'b1, 24'h000000, 24'h0, "sqrt_0");
        run_op(1'b1, 24'hFFFFFF, 24'h0, "sqrt_max");

        // start during BUSY is ignored
        @(negedge clk);
        go(1'b0, 24'hF00000, 24'h900000, 5, "spur");
        count_dones(40, nd);
        check_val("spur_single_done", nd, 0);

        // back-to-back: new start while in the DONE cycle
        run_op(1'b0, 24'h812345, 24'hFEDCBA, "b2b_a");
        go(1'b1, 24'hC3C3C3, 24'h0, 0, "b2b_b");
        go(1'b0, 24'hFFFFFF, 24'h800001, 0, "b2b_c");

        // kill mid-operation
        @(negedge clk);
        bus.div_start_i = 1'b1;
        bus.op_a_i = 24'h900000;
        bus.op_b_i = 24'hA00000;
        tick();
        bus.div_start_i = 1'b0;
        repeat (8) tick();
        bus.kill_i = 1'b1;
        tick();
        bus.kill_i = 1'b0;
        check_val("kill_ready", bus.ready_o, 1);
        check_val("kill_done", bus.done_o, 0);
        count_dones(40, nd);
        check_val("kill_no_done", nd, 0);
        check_val("kill_result_kept", bus.result_o, last_res);

        // kill beats a same-cycle start
        @(negedge clk);
        bus.sqrt_start_i = 1'b1;
        bus.kill_i = 1'b1;
        tick();
        bus.sqrt_start_i = 1'b0;
        bus.kill_i = 1'b0;
        check_val("kill_vs_start_ready", bus.ready_o, 1);
        count_dones(40, nd);
        check_val("kill_vs_start_no_done", nd, 0);

        // reset mid-operation clears outputs
        @(negedge clk);
        bus.div_start_i = 1'b1;
        bus.op_a_i = 24'hC00000;
        bus.op_b_i = 24'h800000;
        tick();
        bus.div_start_i = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        check_val("rst_mid_result", bus.result_o, 0);
        check_val("rst_mid_ready", bus.ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(40, nd);
        check_val("rst_mid_no_done", nd, 0);

        // randomized normalized operands
        for (int i = 0; i < 20; i++) begin
            ra = 24'($urandom) | 24'h800000;
            rb = 24'($urandom) | 24'h800000;
            run_op(1'b0, ra, rb, "rnd_div");
        end
        for (int i = 0; i < 20; i++) begin
            ra = 24'($urandom);
            if (i % 2 == 0) ra = ra | 24'h800000;
            run_op(1'b1, ra, 24'h0, "rnd_sqrt");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
